// File: rtl/cond_logic_pkg.sv
// Shared constants for the conditional-execution stage: condition codes,
// NZCV bit positions and flag-write request bit positions.
package cond_logic_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purely combinational ARM condition-code evaluator: (cond, NZCV) -> cond_pass.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, gates decoder write strobes.
// Optional performance counters enabled by defining COND_PERF_CNT_EN.
module cond_logic
    import cond_logic_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic       cond_pass;
    logic [3:0] flags_d;

    // Evaluation uses the stored flags only, never this cycle's alu_flags.
    cond_check u_cond_check (
        .cond      (cond),
        .flags     (flags_q),
        .cond_pass (cond_pass)
    );

    assign cond_ex   = instr_valid & cond_pass;
    assign pc_src    = pcs & cond_ex;
    assign reg_write = reg_w & cond_ex;
    assign mem_write = mem_w & cond_ex;

    always_comb begin
        flags_d = flags_q;
        if (cond_ex && flag_w[FLAGW_NZ]) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (cond_ex && flag_w[FLAGW_CV]) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (cond_ex) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if (instr_valid && !cond_pass) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign exec_cnt   = exec_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    assign exec_cnt   = '0;
    assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard testbench for cond_logic: directed vectors push expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_cond_logic;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             instr_valid;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs;
    logic             reg_w;
    logic             mem_w;
    logic             pc_src;
    logic             reg_write;
    logic             mem_write;
    logic             cond_ex;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] squash_cnt;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_w      (flag_w),
        .pcs         (pcs),
        .reg_w       (reg_w),
        .mem_w       (mem_w),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .cond_ex     (cond_ex),
        .flags_q     (flags_q),
        .exec_cnt    (exec_cnt),
        .squash_cnt  (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flag_w;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       exp_pc;
        logic       exp_reg;
        logic       exp_mem;
        logic       exp_ex;
        logic [3:0] exp_flags;
    } vec_t;

    typedef struct {
        int               idx;
        logic             exp_pc;
        logic             exp_reg;
        logic             exp_mem;
        logic             exp_ex;
        logic [3:0]       exp_flags;
        logic [CNT_W-1:0] exp_exec;
        logic [CNT_W-1:0] exp_squash;
    } exp_t;

    exp_t             score_q[$];
    vec_t             vecs[30];
    int               test_count = 0;
    int               fail_count = 0;
    logic [CNT_W-1:0] model_exec = '0;
    logic [CNT_W-1:0] model_squash = '0;

    function automatic vec_t mk(logic r, logic v, logic [3:0] c, logic [3:0] a,
                                logic [1:0] fw, logic p, logic rw, logic mw,
                                logic ep, logic er, logic em, logic ee,
                                logic [3:0] ef);
        vec_t t;
        t.rst_n = r; t.valid = v; t.cond = c; t.alu = a; t.flag_w = fw;
        t.pcs = p; t.reg_w = rw; t.mem_w = mw;
        t.exp_pc = ep; t.exp_reg = er; t.exp_mem = em; t.exp_ex = ee;
        t.exp_flags = ef;
        return t;
    endfunction

    // Drive one cycle of inputs and push what the DUT must show this cycle.
    task automatic applyStimulus(input int idx, input vec_t v);
        exp_t e;
        rst_n       = v.rst_n;
        instr_valid = v.valid;
        cond        = v.cond;
        alu_flags   = v.alu;
        flag_w      = v.flag_w;
        pcs         = v.pcs;
        reg_w       = v.reg_w;
        mem_w       = v.mem_w;
        if (!v.rst_n) begin
            model_exec   = '0;
            model_squash = '0;
        end
        e.idx       = idx;
        e.exp_pc    = v.exp_pc;
        e.exp_reg   = v.exp_reg;
        e.exp_mem   = v.exp_mem;
        e.exp_ex    = v.exp_ex;
        e.exp_flags = v.exp_flags;
`ifdef COND_PERF_CNT_EN
        e.exp_exec   = model_exec;
        e.exp_squash = model_squash;
`else
        e.exp_exec   = '0;
        e.exp_squash = '0;
`endif
        score_q.push_back(e);
        if (v.rst_n) begin
            model_exec   = model_exec + CNT_W'(v.exp_ex);
            model_squash = model_squash + CNT_W'(v.valid & ~v.exp_ex);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        test_count++;
        if ({pc_src, reg_write, mem_write, cond_ex} !=
            {e.exp_pc, e.exp_reg, e.exp_mem, e.exp_ex}) begin
            fail_count++;
            $display("[TB] FAIL strobes vec %0d: got pc/reg/mem/ex=%b%b%b%b expected %b%b%b%b",
                     e.idx, pc_src, reg_write, mem_write, cond_ex,
                     e.exp_pc, e.exp_reg, e.exp_mem, e.exp_ex);
        end
        test_count++;
        if (flags_q !== e.exp_flags) begin
            fail_count++;
            $display("[TB] FAIL flags vec %0d: got %b expected %b",
                     e.idx, flags_q, e.exp_flags);
        end
        test_count++;
        if (exec_cnt !== e.exp_exec) begin
            fail_count++;
            $display("[TB] FAIL exec_cnt vec %0d: got %0d expected %0d",
                     e.idx, exec_cnt, e.exp_exec);
        end
        test_count++;
        if (squash_cnt !== e.exp_squash) begin
            fail_count++;
            $display("[TB] FAIL squash_cnt vec %0d: got %0d expected %0d",
                     e.idx, squash_cnt, e.exp_squash);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle whenever
    // an expectation is pending.
    always @(negedge clk) begin
        if (score_q.size() > 0) begin
            checkOutput(score_q.pop_front());
        end
    end

    initial begin
        //            rst valid cond   alu      fw     pcs rw mw   pc rg mm ex flags
        vecs[0]  = mk(0, 1, 4'b0000, 4'b1111, 2'b11, 1, 0, 0,  0, 0, 0, 0, 4'b0000);
        vecs[1]  = mk(1, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0,  0, 0, 0, 1, 4'b0000);
        vecs[2]  = mk(1, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0,  0, 1, 0, 1, 4'b0100);
        vecs[3]  = mk(1, 1, 4'b0001, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0, 4'b0100);
        vecs[4]  = mk(1, 1, 4'b1110, 4'b0011, 2'b11, 0, 0, 0,  0, 0, 0, 1, 4'b0100);
        vecs[5]  = mk(1, 1, 4'b1110, 4'b1000, 2'b10, 0, 0, 0,  0, 0, 0, 1, 4'b0011);
        vecs[6]  = mk(1, 1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0,  0, 0, 0, 1, 4'b1011);
        vecs[7]  = mk(1, 1, 4'b0000, 4'b0100, 2'b11, 0, 0, 1,  0, 0, 0, 0, 4'b0000);
        vecs[8]  = mk(1, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 1,  0, 0, 1, 1, 4'b0000);
        vecs[9]  = mk(1, 1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0,  0, 0, 0, 1, 4'b0000);
        vecs[10] = mk(1, 1, 4'b1010, 4'b0000, 2'b00, 1, 0, 0,  0, 0, 0, 0, 4'b1000);
        vecs[11] = mk(1, 1, 4'b1011, 4'b0000, 2'b00, 1, 0, 0,  1, 0, 0, 1, 4'b1000);
        vecs[12] = mk(1, 1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0,  0, 0, 0, 1, 4'b1000);
        vecs[13] = mk(1, 1, 4'b1100, 4'b0000, 2'b00, 0, 1, 0,  0, 1, 0, 1, 4'b1001);
        vecs[14] = mk(1, 1, 4'b1101, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0, 4'b1001);
        vecs[15] = mk(1, 1, 4'b1111, 4'b0000, 2'b11, 1, 1, 1,  0, 0, 0, 0, 4'b1001);
        vecs[16] = mk(1, 1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0,  0, 0, 0, 1, 4'b1001);
        vecs[17] = mk(1, 1, 4'b1111, 4'b0000, 2'b11, 1, 1, 1,  0, 0, 0, 0, 4'b1111);
        vecs[18] = mk(1, 1, 4'b0010, 4'b0000, 2'b00, 0, 1, 0,  0, 1, 0, 1, 4'b1111);
        vecs[19] = mk(1, 1, 4'b1000, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0, 4'b1111);
        vecs[20] = mk(1, 1, 4'b1001, 4'b0000, 2'b00, 0, 1, 0,  0, 1, 0, 1, 4'b1111);
        vecs[21] = mk(1, 1, 4'b0111, 4'b0000, 2'b00, 0, 1, 0,  0, 0, 0, 0, 4'b1111);
        vecs[22] = mk(1, 1, 4'b0100, 4'b0000, 2'b00, 1, 0, 0,  1, 0, 0, 1, 4'b1111);
        vecs[23] = mk(1, 1, 4'b0101, 4'b0000, 2'b00, 1, 0, 0,  0, 0, 0, 0, 4'b1111);
        vecs[24] = mk(1, 0, 4'b1110, 4'b0000, 2'b11, 1, 1, 1,  0, 0, 0, 0, 4'b1111);
        vecs[25] = mk(1, 1, 4'b0110, 4'b0000, 2'b00, 0, 0, 1,  0, 0, 1, 1, 4'b1111);
        vecs[26] = mk(0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0,  0, 0, 0, 0, 4'b0000);
        vecs[27] = mk(1, 1, 4'b1110, 4'b0010, 2'b11, 0, 0, 0,  0, 0, 0, 1, 4'b0000);
        vecs[28] = mk(1, 1, 4'b0010, 4'b0000, 2'b00, 1, 0, 0,  1, 0, 0, 1, 4'b0010);
        vecs[29] = mk(1, 1, 4'b0011, 4'b0000, 2'b00, 1, 0, 0,  0, 0, 0, 0, 4'b0010);

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        cond        = 4'b0000;
        alu_flags   = 4'b0000;
        flag_w      = 2'b00;
        pcs         = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(i, vecs[i]);
        end

        // 256 passing instructions: an 8-bit exec counter returns to its start.
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(100 + i, mk(1, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0,
                                      0, 1, 0, 1, 4'b0010));
        end

        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        test_count++;
        if (score_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", score_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
